pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and forwarding controller for the five-stage pipelined CPU. It tracks the destination registers of the instructions in EX and MEM and inspects the source registers of the instruction in ID. From these it drives one-cycle load-use stalls, branch-taken flushes, and the registered forwarding selects used by the EX-stage operand muxes. It sits beside the ID/EX pipeline register; X31 (XZR) is never a hazard or forwarding source.

## Interface
Parameters:
- REG_W, 5, register index width
- ZERO_REG, 31, index of XZR; excluded from all comparisons
- CNT_W, 16, width of performance counters (only with HAZARD_PERF_CNT_EN)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rn  in  REG_W  first source register of ID instruction
- id_rm  in  REG_W  second source register, as resolved by decode (Rt for STUR/CBZ)
- id_rd  in  REG_W  destination register of ID instruction
- id_reg_write  in  1  ID instruction writes id_rd
- id_mem_read  in  1  ID instruction is a load (LDUR)
- ex_branch_taken  in  1  branch in EX resolved taken
- stall  out  1  hold PC and IF/ID; bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_b  out  2  EX operand B select, same encoding
- stall_count  out  CNT_W  stall cycles (HAZARD_PERF_CNT_EN only)
- flush_count  out  CNT_W  flush cycles (HAZARD_PERF_CNT_EN only)

## Operation
- Tracking entries:
  - ex_e holds the instruction now in EX as {rd, rw, load, valid}.
  - mem_e holds the instruction now in MEM as {rd, rw, valid}.
  - A bubble is an entry with valid=0, rw=0, load=0.
- FSM states:
  - RUN: normal.
  - STALL: the last cycle inserted a load-use bubble.
  - FLUSH: the last cycle flushed.
- Load-use condition: in RUN or FLUSH, id_valid and ex_e.valid and ex_e.load and ex_e.rw and ex_e.rd != ZERO_REG and (ex_e.rd == id_rn or ex_e.rd == id_rm).
- flush = ex_branch_taken and state != FLUSH. In FLUSH, EX holds a bubble, so ex_branch_taken is ignored.
- stall = load-use condition and not flush. Flush has priority over stall.
- Both stall and flush are combinational outputs, valid in the same cycle as their cause.
- Per-clock update:
  - mem_e <= ex_e.
  - ex_e <= bubble if stall, flush, or !id_valid; otherwise the ID fields.
- Next-state:
  - flush → FLUSH.
  - stall → STALL.
  - otherwise → RUN.
  - STALL cannot repeat: the bubble now in EX clears the load-use condition.
- Forward select computation for fwd_a (id_rn) and fwd_b (id_rm), registered into the EX cycle:
  - 01 if ex_e.rw and ex_e.rd == src and src != ZERO_REG.
  - Else 10 if mem_e.rw and mem_e.rd == src and src != ZERO_REG.
  - Else 00.
  - EX/MEM takes priority over MEM/WB.
- fwd_a/fwd_b load 00 when stall, flush, or !id_valid.

## Timing
- Reset, asynchronous and immediate:
  - state = RUN.
  - ex_e and mem_e = bubble.
  - fwd_a = fwd_b = 00.
  - Counters = 0.
  - stall = flush = 0 while rst_n is low.
- Latency of stall/flush: 0 cycles, combinational from inputs and tracking state.
- Latency of fwd_*: 1 cycle. The value computed in the ID cycle is presented while that instruction is in EX.
- A load followed by a dependent instruction gives exactly one stall cycle. The dependent instruction then reaches EX with fwd=10.
- Simultaneous ex_branch_taken and load-use: flush=1, stall=0, next state FLUSH.
- Reset mid-stall: the pipeline restarts in RUN with no pending bubble.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each cycle with flush=1.
  - Both counters saturate at all-ones.
  - Both ports exist.
- HAZARD_PERF_CNT_EN undefined: the counters and their ports are absent. All other behaviour is identical.

## Structure
- Shared package hazard_pkg:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - hz_state_t enum: RUN, STALL, FLUSH.
  - stage_entry_t struct: rd, rw, load, valid.
  - Constant XZR=5'd31.
- One sub-module: fwd_select. It is combinational, takes src, ex_e and mem_e, and returns fwd_sel_t. It is instantiated twice, for operands A and B.

## Test plan
- ADD X1 in EX (rw=1), ID SUB with Rn=1, Rm=2 → next cycle fwd_a=01, fwd_b=00, stall=0.
- LDUR X3 in EX, ID ADD with Rm=3 → stall=1 for exactly one cycle; following cycle fwd_b=10, state RUN.
- ADD X31 in EX, ID Rn=31 → fwd_a=00, no stall. Also: LDUR X31 followed by a user of X31 → no stall.
- X5 written by both EX and MEM, ID Rn=5 → fwd_a=01 (EX priority). Same case with EX rw=0 → fwd_a=10.
- ex_branch_taken=1 together with a load-use condition → flush=1, stall=0. Next cycle ex_branch_taken=1 is held → flush=0 (FLUSH state). flush_count=1 with HAZARD_PERF_CNT_EN.
- Assert rst_n=0 during stall=1 → stall drops immediately. After release, fwd_a=fwd_b=00 and state RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

   localparam int             HZ_REG_W = 5;
   localparam logic [4:0]     XZR      = 5'd31;

   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN,
      STALL,
      FLUSH
   } hz_state_t;

   typedef struct packed {
      logic [HZ_REG_W-1:0] rd;
      logic                rw;
      logic                load;
      logic                valid;
   } stage_entry_t;

   localparam stage_entry_t BUBBLE = '{rd: '0, rw: 1'b0, load: 1'b0, valid: 1'b0};

endpackage

// File: rtl/fwd_select.sv
// Combinational forwarding-source select for one EX operand; EX/MEM wins over MEM/WB,
// and the zero register never forwards.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int ZERO_REG = 31
) (
   input  logic [REG_W-1:0] src,
   input  stage_entry_t     ex_e,
   input  stage_entry_t     mem_e,
   output fwd_sel_t         sel
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   // The load flag matters only for load-use detection, not for forwarding.
   logic unused_load;
   assign unused_load = ex_e.load ^ mem_e.load;

   // NOTE: sel gets its default first so no path through the block leaves it unassigned (no latch).
   always_comb begin
      sel = FWD_REG;
      if (src != ZR) begin
         if (ex_e.valid && ex_e.rw && ex_e.rd == src)
            sel = FWD_EXMEM;
         else if (mem_e.valid && mem_e.rw && mem_e.rd == src)
            sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and registered forwarding-select controller for the 5-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int ZERO_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
`endif
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   hz_state_t    state, state_nxt;
   stage_entry_t ex_e, mem_e, id_e;
   fwd_sel_t     fwd_a_nxt, fwd_b_nxt, fwd_a_q, fwd_b_q;
   logic         load_use, insert_bubble;

   fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
      .src(id_rn), .ex_e(ex_e), .mem_e(mem_e), .sel(fwd_a_nxt)
   );

   fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
      .src(id_rm), .ex_e(ex_e), .mem_e(mem_e), .sel(fwd_b_nxt)
   );

   assign id_e = '{rd: id_rd, rw: id_reg_write, load: id_mem_read, valid: 1'b1};

   // Flush is gated by rst_n because ex_branch_taken may be high while reset is asserted.
   always_comb begin
      load_use  = 1'b0;
      flush     = 1'b0;
      stall     = 1'b0;
      state_nxt = RUN;
      if (rst_n) begin
         load_use = (state != STALL) && id_valid && ex_e.valid && ex_e.load && ex_e.rw &&
                    (ex_e.rd != ZR) && (ex_e.rd == id_rn || ex_e.rd == id_rm);
         flush    = ex_branch_taken && (state != FLUSH);
         stall    = load_use && !flush;
      end
      if (flush)
         state_nxt = FLUSH;
      else if (stall)
         state_nxt = STALL;
   end

   assign insert_bubble = stall || flush || !id_valid;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         ex_e    <= BUBBLE;
         mem_e   <= BUBBLE;
         fwd_a_q <= FWD_REG;
         fwd_b_q <= FWD_REG;
      end else begin
         state   <= state_nxt;
         mem_e   <= ex_e;
         ex_e    <= insert_bubble ? BUBBLE : id_e;
         fwd_a_q <= insert_bubble ? FWD_REG : fwd_a_nxt;
         fwd_b_q <= insert_bubble ? FWD_REG : fwd_b_nxt;
      end
   end

   assign fwd_a = fwd_a_q;
   assign fwd_b = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
   // Saturating event counters; they stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall && stall_count != '1)
            stall_count <= stall_count + 1'b1;
         if (flush && flush_count != '1)
            flush_count <= flush_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed test-plan sequences then random traffic,
// checked against an instruction-level reference model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_reg_write, id_mem_read, ex_branch_taken;
   logic [4:0] id_rn, id_rm, id_rd;
   logic       stall, flush;
   logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_count, flush_count;
`endif

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_branch_taken(ex_branch_taken),
      .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   typedef struct {
      bit valid;
      int rd;
      bit rw;
      bit load;
   } instr_t;

   typedef struct {
      bit stall;
      bit flush;
      int fa;
      int fb;
      int sc;
      int fc;
   } exp_t;

   exp_t   sb[$];
   instr_t m_ex, m_mem;
   bit     m_last_stall, m_last_flush;
   int     m_fa, m_fb, m_sc, m_fc;
   int     checks = 0;
   int     errors = 0;
   int     regs[6] = '{1, 2, 3, 4, 5, 31};

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_ex         = '{default: 0};
      m_mem        = '{default: 0};
      m_last_stall = 0;
      m_last_flush = 0;
      m_fa         = 0;
      m_fb         = 0;
      m_sc         = 0;
      m_fc         = 0;
   endfunction

   // Which older in-flight instruction produces src: 1 = the one in EX, 2 = the one in MEM.
   function automatic int producer(int src);
      if (src == 31) return 0;
      if (m_ex.valid && m_ex.rw && m_ex.rd == src) return 1;
      if (m_mem.valid && m_mem.rw && m_mem.rd == src) return 2;
      return 0;
   endfunction

   task automatic drive(bit v, int rn, int rm, int rd, bit rw, bit mr, bit br);
      exp_t e;
      bit   lu, bub;
      @(posedge clk);
      #1;
      id_valid        = v;
      id_rn           = rn[4:0];
      id_rm           = rm[4:0];
      id_rd           = rd[4:0];
      id_reg_write    = rw;
      id_mem_read     = mr;
      ex_branch_taken = br;

      e.flush = br && !m_last_flush;
      lu      = !m_last_stall && v && m_ex.valid && m_ex.load && m_ex.rw && m_ex.rd != 31 &&
                (m_ex.rd == rn || m_ex.rd == rm);
      e.stall = lu && !e.flush;
      e.fa    = m_fa;
      e.fb    = m_fb;
      e.sc    = m_sc;
      e.fc    = m_fc;
      sb.push_back(e);

      bub          = e.stall || e.flush || !v;
      m_fa         = bub ? 0 : producer(rn);
      m_fb         = bub ? 0 : producer(rm);
      m_mem        = m_ex;
      m_ex         = bub ? '{default: 0} : '{valid: 1'b1, rd: rd, rw: rw, load: mr};
      m_last_stall = e.stall;
      m_last_flush = e.flush;
      m_sc        += int'(e.stall);
      m_fc        += int'(e.flush);
   endtask

   task automatic idle_inputs();
      id_valid        = 1'b0;
      id_rn           = '0;
      id_rm           = '0;
      id_rd           = '0;
      id_reg_write    = 1'b0;
      id_mem_read     = 1'b0;
      ex_branch_taken = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         check("stall", 32'(stall), 32'(e.stall));
         check("flush", 32'(flush), 32'(e.flush));
         check("fwd_a", 32'(fwd_a), e.fa);
         check("fwd_b", 32'(fwd_b), e.fb);
`ifdef HAZARD_PERF_CNT_EN
         check("stall_count", 32'(stall_count), e.sc);
         check("flush_count", 32'(flush_count), e.fc);
`endif
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int rn, rm, rd;
      bit v, rw, mr, br;
      idle_inputs();
      ex_branch_taken = 1'b1;
      rst_n = 1'b0;
      model_reset();
      #3;
      check("reset_stall", 32'(stall), 0);
      check("reset_flush", 32'(flush), 0);
      check("reset_fwd_a", 32'(fwd_a), 0);
      check("reset_fwd_b", 32'(fwd_b), 0);
      idle_inputs();
      #9 rst_n = 1'b1;

      // EX/MEM forwarding of an ALU result
      drive(1, 2, 3, 1, 1, 0, 0);
      drive(1, 1, 2, 6, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      // load-use: one stall, then MEM/WB forward on operand B
      drive(1, 4, 5, 3, 1, 1, 0);
      drive(1, 7, 3, 8, 1, 0, 0);
      drive(1, 7, 3, 8, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      // XZR never forwards or stalls
      drive(1, 1, 2, 31, 1, 0, 0);
      drive(1, 31, 2, 9, 1, 0, 0);
      drive(1, 1, 2, 31, 1, 1, 0);
      drive(1, 31, 31, 9, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      // X5 in EX and MEM: EX wins; then EX not writing: MEM wins
      drive(1, 1, 2, 5, 1, 0, 0);
      drive(1, 1, 2, 5, 1, 0, 0);
      drive(1, 5, 2, 9, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 2, 5, 1, 0, 0);
      drive(1, 1, 2, 5, 0, 0, 0);
      drive(1, 5, 2, 9, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      // branch taken with load-use: flush wins, held branch ignored in FLUSH
      drive(1, 4, 5, 3, 1, 1, 0);
      drive(1, 7, 3, 8, 1, 0, 1);
      drive(1, 7, 3, 8, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0);

      // reset asserted while stall is high
      drive(1, 4, 5, 3, 1, 1, 0);
      drive(1, 7, 3, 8, 1, 0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      ex_branch_taken = 1'b1;
      #1;
      check("rst_mid_stall", 32'(stall), 0);
      check("rst_mid_flush", 32'(flush), 0);
      check("rst_mid_fwd_a", 32'(fwd_a), 0);
      check("rst_mid_fwd_b", 32'(fwd_b), 0);
      idle_inputs();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      // dependent user right after reset must not stall on a forgotten load
      drive(1, 3, 3, 8, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 2000; i++) begin
         v  = ($urandom_range(0, 7) != 0);
         rn = regs[$urandom_range(0, 5)];
         rm = regs[$urandom_range(0, 5)];
         rd = regs[$urandom_range(0, 5)];
         rw = ($urandom_range(0, 3) != 0);
         mr = rw && ($urandom_range(0, 2) == 0);
         br = ($urandom_range(0, 7) == 0);
         drive(v, rn, rm, rd, rw, mr, br);
      end

      repeat (4) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
